// File: rtl/spi_shift_register.sv
// spi_shift_register
// Serial data path of the APB SPI master. Loads a parallel TX word and drives
// mosi on the shift strobe. Samples miso on the sample strobe. The baud
// generator supplies both strobes as flag_high/flag_low, and cpol/cpha pick
// which flag plays which role. The received word is returned on data_miso
// with a one-cycle receive_data pulse.
// Optional build macro: SPI_SHIFT_LOOPBACK_EN. When it is defined, the internal
// mosi register is sampled in place of the miso port.
module spi_shift_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  ss,
    input  logic                  send_data,
    input  logic [DATA_WIDTH-1:0] data_mosi,
    input  logic                  lsbfe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  flag_high,
    input  logic                  flag_low,
    input  logic                  miso,
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] data_miso,
    output logic                  busy,
    output logic                  receive_data
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_lsbfe;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_mosi;
    logic [DATA_WIDTH-1:0] r_data_miso;
    logic                  r_receive_data;

    logic                  w_start;
    logic                  w_sample;
    logic                  w_shift;
    logic                  w_shift_ok;
    logic                  w_miso_in;
    logic                  w_first_bit;
    logic [DATA_WIDTH-1:0] w_rx_next;

`ifdef SPI_SHIFT_LOOPBACK_EN
    // The transmitted bit is looped straight back, so a transfer returns its own TX word.
    assign w_miso_in = r_mosi;
`else
    assign w_miso_in = miso;
`endif

    assign w_start     = send_data && !ss;
    assign w_first_bit = lsbfe ? data_mosi[0] : data_mosi[DATA_WIDTH-1];

    // Modes 0 and 3 sample on the rising sclk edge. Modes 1 and 2 sample on the falling edge.
    assign w_sample = (r_cpol == r_cpha) ? flag_high : flag_low;
    assign w_shift  = (r_cpol == r_cpha) ? flag_low  : flag_high;

    // The first bit is already on mosi at load time, so a leading shift edge (cpha=1) is skipped.
    assign w_shift_ok = w_shift && (r_bit_cnt != '0) && (r_bit_cnt < FULL_CNT);

    // The received word fills from the end opposite to the one the first bit should land in.
    assign w_rx_next = r_lsbfe ? {w_miso_in, r_rx[DATA_WIDTH-1:1]}
                               : {r_rx[DATA_WIDTH-2:0], w_miso_in};

    // State register.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential logic uses non-blocking '<=' so every register sees pre-edge values.
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. An abort (ss high) takes priority over a sample strobe.
    always_comb begin
        // NOTE: the default is assigned first, so no path leaves w_next_state unassigned and no latch forms.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_XFER;
                end
            end
            ST_XFER: begin
                if (ss) begin
                    w_next_state = ST_IDLE;
                end else if (w_sample && (r_bit_cnt == LAST_BIT)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: load on start, sample/shift on strobes, publish the word in DONE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx           <= '0;
            r_rx           <= '0;
            r_bit_cnt      <= '0;
            r_lsbfe        <= 1'b0;
            r_cpol         <= 1'b0;
            r_cpha         <= 1'b0;
            r_mosi         <= 1'b0;
            r_data_miso    <= '0;
            r_receive_data <= 1'b0;
        end else begin
            r_receive_data <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mosi    <= 1'b0;
                    r_bit_cnt <= '0;
                    if (w_start) begin
                        r_tx    <= data_mosi;
                        r_rx    <= '0;
                        r_lsbfe <= lsbfe;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_mosi  <= w_first_bit;
                    end
                end
                ST_XFER: begin
                    if (ss) begin
                        r_mosi    <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_sample) begin
                        r_rx      <= w_rx_next;
                        r_bit_cnt <= r_bit_cnt + CNT_ONE;
                    end else if (w_shift_ok) begin
                        if (r_lsbfe) begin
                            r_tx   <= r_tx >> 1;
                            r_mosi <= r_tx[1];
                        end else begin
                            r_tx   <= r_tx << 1;
                            r_mosi <= r_tx[DATA_WIDTH-2];
                        end
                    end
                end
                ST_DONE: begin
                    r_data_miso    <= r_rx;
                    r_receive_data <= 1'b1;
                    r_mosi         <= 1'b0;
                    r_bit_cnt      <= '0;
                end
                default: begin
                    r_mosi <= 1'b0;
                end
            endcase
        end
    end

    assign mosi         = r_mosi;
    assign data_miso    = r_data_miso;
    assign busy         = (r_state == ST_XFER);
    assign receive_data = r_receive_data;

endmodule

// File: tb/tb_spi_shift_register.sv
// Testbench for spi_shift_register. The bench acts as the baud generator and
// the slave. It checks the bits seen on mosi and the word returned on
// data_miso against values derived from the SPI rules.
module tb_spi_shift_register;

    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          ss;
    logic          send_data;
    logic [DW-1:0] data_mosi;
    logic          lsbfe;
    logic          cpol;
    logic          cpha;
    logic          flag_high;
    logic          flag_low;
    logic          miso;
    logic          mosi;
    logic [DW-1:0] data_miso;
    logic          busy;
    logic          receive_data;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] last_word;

`ifdef SPI_SHIFT_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    spi_shift_register #(.DATA_WIDTH(DW)) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .ss           (ss),
        .send_data    (send_data),
        .data_mosi    (data_mosi),
        .lsbfe        (lsbfe),
        .cpol         (cpol),
        .cpha         (cpha),
        .flag_high    (flag_high),
        .flag_low     (flag_low),
        .miso         (miso),
        .mosi         (mosi),
        .data_miso    (data_miso),
        .busy         (busy),
        .receive_data (receive_data)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          cp;
        logic          ch;
        logic          lf;
        logic [DW-1:0] tx;
        logic [DW-1:0] sl;
        int            abort_after;
        int            inject_at;
        int            both_at;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    // The word a completed transfer returns: the slave's word, or the TX word in loopback.
    function automatic logic [DW-1:0] pick(input logic [DW-1:0] tx, input logic [DW-1:0] sl);
        return LOOPBACK ? tx : sl;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic gap(input int gmax);
        repeat ($urandom_range(gmax, 0)) cyc();
    endtask

    // One strobe cycle. hi selects flag_high or flag_low. both raises the two flags together.
    task automatic strobe(input bit hi, input bit both);
        flag_high = hi | both;
        flag_low  = !hi | both;
        cyc();
        flag_high = 1'b0;
        flag_low  = 1'b0;
    endtask

    // A full transfer driven like the baud generator plus a slave.
    task automatic do_xfer(input logic cp, input logic ch, input logic lf,
                           input logic [DW-1:0] tx, input logic [DW-1:0] sl,
                           input int abort_after, input int inject_at, input int both_at,
                           input int gap_max, input logic [DW-1:0] exp_word, input string tag);
        logic [DW-1:0] seen;
        bit            samp_hi;
        bit            got;
        int            n;
        // Modes 0 and 3 sample on rising sclk edges. Modes 1 and 2 sample on falling edges.
        samp_hi = (cp == ch);
        seen    = '0;
        ss = 1'b0; data_mosi = tx; lsbfe = lf; cpol = cp; cpha = ch; send_data = 1'b1;
        cyc();
        send_data = 1'b0;
        // These changes must not affect a transfer that is already running.
        data_mosi = ~tx; lsbfe = ~lf; cpol = ~cp; cpha = ~ch;
        check({tag, " busy_start"}, busy, 1);
        for (int b = 0; b < DW; b++) begin
            int idx;
            idx = lf ? b : DW - 1 - b;
            if (b == abort_after) begin
                ss = 1'b1;
                cyc();
                check({tag, " abort_busy"}, busy, 0);
                check({tag, " abort_mosi"}, mosi, 0);
                got = 1'b0;
                repeat (3) begin
                    if (receive_data) got = 1'b1;
                    cyc();
                end
                check({tag, " abort_no_pulse"}, got, 0);
                check({tag, " abort_data_miso"}, data_miso, exp_word);
                ss = 1'b0;
                return;
            end
            if (b == inject_at) begin
                data_mosi = 8'hFF; send_data = 1'b1;
                cyc();
                send_data = 1'b0;
            end
            if (ch) begin
                strobe(!samp_hi, 1'b0);
                gap(gap_max);
            end
            seen[idx] = mosi;
            miso      = sl[idx];
            strobe(samp_hi, b == both_at);
            if (b == DW - 1) break;
            gap(gap_max);
            if (!ch) begin
                strobe(!samp_hi, 1'b0);
                gap(gap_max);
            end
        end
        miso = 1'b0;
        check({tag, " mosi_word"}, seen, tx);
        n = 0;
        while (!receive_data && n < 4) begin
            cyc();
            n++;
        end
        check({tag, " pulse_latency"}, n, 1);
        check({tag, " data_miso"}, data_miso, exp_word);
        check({tag, " busy_at_pulse"}, busy, 0);
        cyc();
        check({tag, " single_pulse"}, receive_data, 0);
        check({tag, " mosi_idle"}, mosi, 0);
        check({tag, " stays_idle"}, busy, 0);
    endtask

    initial begin
        PRESET = 1'b1; ss = 1'b1; send_data = 1'b0; data_mosi = '0; lsbfe = 1'b0;
        cpol = 1'b0; cpha = 1'b0; flag_high = 1'b0; flag_low = 1'b0; miso = 1'b0;
        repeat (2) cyc();
        check("reset mosi", mosi, 0);
        check("reset data_miso", data_miso, 0);
        check("reset busy", busy, 0);
        check("reset receive_data", receive_data, 0);
        PRESET = 1'b0;
        last_word = '0;
        cyc();

        // send_data with ss high must be ignored.
        ss = 1'b1; data_mosi = 8'h99; send_data = 1'b1;
        cyc();
        send_data = 1'b0;
        check("ss_high busy", busy, 0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        check("ss_high still idle", busy, 0);
        check("ss_high mosi", mosi, 0);
        check("ss_high no pulse", receive_data, 0);

        // Directed table.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, -1, -1, -1, pick(8'hA5, 8'h3C)};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h0F, 8'hF0,  4, -1, -1, pick(8'hA5, 8'h3C)};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h5A, -1, -1, -1, pick(8'h81, 8'h5A)};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h6B, 8'h94, -1,  3, -1, pick(8'h6B, 8'h94)};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'hC3, 8'h00, -1, -1, -1, pick(8'hC3, 8'h00)};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h5E, 8'hE5, -1, -1,  3, pick(8'h5E, 8'hE5)};
        for (int i = 0; i < 6; i++) begin
            do_xfer(vecs[i].cp, vecs[i].ch, vecs[i].lf, vecs[i].tx, vecs[i].sl,
                    vecs[i].abort_after, vecs[i].inject_at, vecs[i].both_at, 1,
                    vecs[i].exp, $sformatf("vec%0d", i));
            if (vecs[i].abort_after < 0) last_word = vecs[i].exp;
            repeat (2) cyc();
        end

        // Reset in the middle of a transfer (bit_cnt = 5), with a send_data request in the same cycle.
        ss = 1'b0; data_mosi = 8'hA5; lsbfe = 1'b0; cpol = 1'b0; cpha = 1'b0; send_data = 1'b1;
        cyc();
        send_data = 1'b0;
        for (int k = 0; k < 5; k++) begin
            miso = 1'b1;
            strobe(1'b1, 1'b0);
            strobe(1'b0, 1'b0);
        end
        check("midreset busy_before", busy, 1);
        PRESET = 1'b1; send_data = 1'b1;
        cyc();
        PRESET = 1'b0; send_data = 1'b0; miso = 1'b0;
        check("midreset mosi", mosi, 0);
        check("midreset data_miso", data_miso, 0);
        check("midreset busy", busy, 0);
        check("midreset receive_data", receive_data, 0);
        cyc();
        check("midreset stays idle", busy, 0);
        last_word = '0;
        do_xfer(1'b0, 1'b0, 1'b0, 8'h3C, 8'hC3, -1, -1, -1, 1, pick(8'h3C, 8'hC3), "post_reset");
        last_word = pick(8'h3C, 8'hC3);

        // Randomized transfers. The expected word comes from the slave/loopback rule, and an abort keeps the previous word.
        for (int r = 0; r < 24; r++) begin
            logic          cp, ch, lf;
            logic [DW-1:0] tx, sl, exp;
            int            ab;
            cp = 1'($urandom); ch = 1'($urandom); lf = 1'($urandom);
            tx = DW'($urandom); sl = DW'($urandom);
            ab = ($urandom_range(5, 0) == 0) ? int'($urandom_range(DW - 1, 1)) : -1;
            exp = (ab >= 0) ? last_word : pick(tx, sl);
            do_xfer(cp, ch, lf, tx, sl, ab, -1, -1, 2, exp, $sformatf("rnd%0d", r));
            last_word = exp;
            gap(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
